// File: rtl/or_gate_8_resp_checker_pkg.sv
// ---------------------------------------------------------------------------
// or_gate_8_resp_checker_pkg : shared FSM encodings and MISR constants
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package or_gate_8_resp_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int MISR_W = 16;

  // Feedback taps s[15], s[13], s[12], s[10]  (x^16 + x^14 + x^13 + x^11 + 1)
  localparam logic [MISR_W-1:0] MISR_TAPS = 16'hB400;

endpackage

`default_nettype wire

// File: rtl/or_gate_8_resp_checker_misr16.sv
// ---------------------------------------------------------------------------
// misr16 : 16-bit multiple-input signature register with sync clear
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module misr16
  import or_gate_8_resp_checker_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic [MISR_W-1:0] din,
  output logic [MISR_W-1:0] sig
);

  logic fb;

  assign fb = ^(sig & MISR_TAPS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig <= '0;
    end else if (clr) begin
      sig <= '0;
    end else if (en) begin
      sig <= {sig[MISR_W-2:0], fb} ^ din;
    end
  end

endmodule

`default_nettype wire

// File: rtl/or_gate_8_resp_checker.sv
// ---------------------------------------------------------------------------
// or_gate_8_resp_checker : checks OR-gate responses over an ascending sweep
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module or_gate_8_resp_checker
  import or_gate_8_resp_checker_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NPAT  = 2**WIDTH,
  parameter int CNT_W = WIDTH + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [WIDTH-1:0]  in_vec,
  input  logic              dut_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  pat_count,
  output logic [CNT_W-1:0]  err_count,
  output logic              seq_err,
  output logic              first_fail_vld,
  output logic [WIDTH-1:0]  first_fail_vec,
  output logic [MISR_W-1:0] signature
);

  localparam logic [CNT_W-1:0] LAST_PAT = CNT_W'(NPAT - 1);

  state_t             state, state_n;
  logic               accept;
  logic               mismatch;
  logic [CNT_W-1:0]   pat_n, err_n;
  logic               seq_n, ffv_n;
  logic [WIDTH-1:0]   ffvec_n;
  logic [MISR_W-1:0]  misr_din;

  always_comb begin
    accept   = in_valid && (state == ST_RUN) && !start;
    mismatch = (dut_out != (|in_vec));
    state_n  = state;
    pat_n    = pat_count;
    err_n    = err_count;
    seq_n    = seq_err;
    ffv_n    = first_fail_vld;
    ffvec_n  = first_fail_vec;

    if (start) begin
      state_n = ST_RUN;
      pat_n   = '0;
      err_n   = '0;
      seq_n   = 1'b0;
      ffv_n   = 1'b0;
      ffvec_n = '0;
    end else if (accept) begin
      pat_n = pat_count + CNT_W'(1);
      if (mismatch && (err_count != '1)) begin
        err_n = err_count + CNT_W'(1);
      end
      if (mismatch && !first_fail_vld) begin
        ffv_n   = 1'b1;
        ffvec_n = in_vec;
      end
      if (in_vec != pat_count[WIDTH-1:0]) begin
        seq_n = 1'b1;
      end
      // Leave RUN on the edge that takes the final sample, so nothing after it is accepted
      if (pat_count == LAST_PAT) begin
        state_n = ST_DONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      pat_count      <= '0;
      err_count      <= '0;
      seq_err        <= 1'b0;
      first_fail_vld <= 1'b0;
      first_fail_vec <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
    end else begin
      state          <= state_n;
      pat_count      <= pat_n;
      err_count      <= err_n;
      seq_err        <= seq_n;
      first_fail_vld <= ffv_n;
      first_fail_vec <= ffvec_n;
      busy           <= (state_n == ST_RUN);
      done           <= (state_n == ST_DONE);
      pass           <= (state_n == ST_DONE) && (err_n == '0) && !seq_n;
    end
  end

  always_comb begin
    misr_din            = '0;
    misr_din[WIDTH:0]   = {dut_out, in_vec};
  end

  misr16 u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start),
    .en    (accept),
    .din   (misr_din),
    .sig   (signature)
  );

endmodule

`default_nettype wire

// File: tb/tb_or_gate_8_resp_checker.sv
// ---------------------------------------------------------------------------
// tb_or_gate_8_resp_checker : scoreboard bench for or_gate_8_resp_checker
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_or_gate_8_resp_checker;

  localparam int WIDTH = 8;
  localparam int CNT_W = 9;
  localparam int NPAT  = 256;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_vec = '0;
  logic             dut_out = 1'b0;
  logic             busy, done, pass, seq_err, first_fail_vld;
  logic [CNT_W-1:0] pat_count, err_count;
  logic [WIDTH-1:0] first_fail_vec;
  logic [15:0]      signature;

  or_gate_8_resp_checker #(.WIDTH(WIDTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .in_valid       (in_valid),
    .in_vec         (in_vec),
    .dut_out        (dut_out),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .pat_count      (pat_count),
    .err_count      (err_count),
    .seq_err        (seq_err),
    .first_fail_vld (first_fail_vld),
    .first_fail_vec (first_fail_vec),
    .signature      (signature)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: expected observable state after each accepted sample
  typedef struct {
    int pat; int err; int seq; int ffv; int ffvec; int sig;
    int busy; int done; int pass;
  } rec_t;

  rec_t q[$];
  bit   m_run, m_done, m_seq, m_ffv;
  int   m_pat, m_err, m_ffvec, m_sig;
  int   sc1_sig;

  function automatic int misr_next(input int s, input int d);
    int fb;
    fb = ((s >> 15) ^ (s >> 13) ^ (s >> 12) ^ (s >> 10)) & 1;
    return (((s << 1) | fb) & 32'hFFFF) ^ d;
  endfunction

  task automatic model_reset();
    m_run = 0; m_done = 0; m_seq = 0; m_ffv = 0;
    m_pat = 0; m_err = 0; m_ffvec = 0; m_sig = 0;
  endtask

  task automatic model_accept(input int vec, input bit out);
    rec_t r;
    bit   expo;
    expo = (vec != 0);
    if (out != expo) begin
      if (m_err < (1 << CNT_W) - 1) m_err++;
      if (!m_ffv) begin m_ffv = 1; m_ffvec = vec; end
    end
    if (vec != (m_pat % NPAT)) m_seq = 1;
    m_sig = misr_next(m_sig, (int'(out) << WIDTH) | vec);
    m_pat++;
    if (m_pat == NPAT) begin m_run = 0; m_done = 1; end
    r.pat = m_pat; r.err = m_err; r.seq = int'(m_seq); r.ffv = int'(m_ffv);
    r.ffvec = m_ffvec; r.sig = m_sig; r.busy = int'(m_run); r.done = int'(m_done);
    r.pass = int'(m_done && m_err == 0 && !m_seq);
    q.push_back(r);
  endtask

  // Monitor: every new sample shows up as a pat_count change one edge after issue
  initial begin
    int   prev;
    rec_t r;
    prev = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev = 0;
      end else if (int'(pat_count) != prev) begin
        if (pat_count != '0) begin
          if (q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_sample: pat_count=%0d with no sample expected", pat_count);
          end else begin
            r = q.pop_front();
            check("pat_count", 32'(pat_count),      32'(r.pat));
            check("err_count", 32'(err_count),      32'(r.err));
            check("seq_err",   32'(seq_err),        32'(r.seq));
            check("ff_vld",    32'(first_fail_vld), 32'(r.ffv));
            check("ff_vec",    32'(first_fail_vec), 32'(r.ffvec));
            check("signature", 32'(signature),      32'(r.sig));
            check("busy",      32'(busy),           32'(r.busy));
            check("done",      32'(done),           32'(r.done));
            check("pass",      32'(pass),           32'(r.pass));
          end
        end
        prev = int'(pat_count);
      end
    end
  end

  task automatic issue(input bit st, input bit v, input int vec, input bit out);
    start    = st;
    in_valid = v;
    in_vec   = WIDTH'(vec);
    dut_out  = out;
    if (st) begin
      model_reset();
      m_run = 1;
    end else if (v && m_run) begin
      model_accept(vec, out);
    end
    @(posedge clk);
    #1;
    start    = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      start = 1'b0; in_valid = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  // mode 0 normal, 2 stuck-at-0, 3 vector 5 replaced by 6; first_n limits the count
  task automatic sweep(input int mode, input int gap_pct, input int first_n);
    int vec;
    issue(1, 0, 0, 0);
    for (int v = 0; v < first_n; v++) begin
      vec = (mode == 3 && v == 5) ? 6 : v;
      while ($urandom_range(99) < gap_pct) idle(1);
      issue(0, 1, vec, (mode == 2) ? 1'b0 : (vec != 0));
    end
    idle(2);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!done && n < 8) begin
      @(posedge clk); #1; n++;
    end
    check({tag, "_done"}, 32'(done), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_pass"}, 32'(pass), 0);
    check({tag, "_pat"},  32'(pat_count), 0);
    check({tag, "_err"},  32'(err_count), 0);
    check({tag, "_seq"},  32'(seq_err), 0);
    check({tag, "_ffv"},  32'(first_fail_vld), 0);
    check({tag, "_ffvec"}, 32'(first_fail_vec), 0);
    check({tag, "_sig"},  32'(signature), 0);
  endtask

  task automatic check_good_sweep(input string tag);
    wait_done(tag);
    check({tag, "_pat"},  32'(pat_count), 256);
    check({tag, "_err"},  32'(err_count), 0);
    check({tag, "_seq"},  32'(seq_err), 0);
    check({tag, "_pass"}, 32'(pass), 1);
    check({tag, "_sig"},  32'(signature), 32'(sc1_sig));
  endtask

  initial begin
    #1;
    check_all_zero("reset");
    #10;
    rst_n = 1'b1;
    @(posedge clk); #1;
    model_reset();

    // in_valid while IDLE is ignored
    for (int i = 0; i < 3; i++) issue(0, 1, i, 1'b1);
    check("idle_ignore_pat", 32'(pat_count), 0);

    // Scenario 1: clean ascending sweep
    sweep(0, 0, NPAT);
    sc1_sig = m_sig;
    wait_done("s1");
    check("s1_pat",  32'(pat_count), 256);
    check("s1_err",  32'(err_count), 0);
    check("s1_seq",  32'(seq_err), 0);
    check("s1_pass", 32'(pass), 1);
    check("s1_sig",  32'(signature), 32'(sc1_sig));

    // Samples after the sweep completes are never accepted
    for (int i = 0; i < 3; i++) issue(0, 1, i, 1'b0);
    check("post_done_pat", 32'(pat_count), 256);
    check("post_done_err", 32'(err_count), 0);
    check("post_done_done", 32'(done), 1);

    // Scenario 2: stuck-at-0 output
    sweep(2, 0, NPAT);
    wait_done("s2");
    check("s2_err",   32'(err_count), 255);
    check("s2_ffv",   32'(first_fail_vld), 1);
    check("s2_ffvec", 32'(first_fail_vec), 32'h01);
    check("s2_pass",  32'(pass), 0);

    // Scenario 3: out-of-order vector
    sweep(3, 0, NPAT);
    wait_done("s3");
    check("s3_seq",  32'(seq_err), 1);
    check("s3_err",  32'(err_count), 0);
    check("s3_pass", 32'(pass), 0);

    // Scenario 4: random in_valid gaps
    sweep(0, 30, NPAT);
    check_good_sweep("s4");

    // Scenario 5: asynchronous reset after 100 samples
    sweep(0, 0, 100);
    check("s5_busy_mid", 32'(busy), 1);
    check("s5_queue_drained", 32'(q.size()), 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("s5_rst");
    model_reset();
    q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);
    sweep(0, 0, NPAT);
    check_good_sweep("s5");

    // Scenario 6: restart at sample 50, then start coincident with in_valid
    sweep(0, 0, 50);
    issue(1, 0, 0, 0);
    check("s6_restart_pat", 32'(pat_count), 0);
    check("s6_restart_busy", 32'(busy), 1);
    for (int v = 0; v < 30; v++) issue(0, 1, v, (v != 0));
    issue(1, 1, $urandom_range(255), 1'b1);
    check("s6_coinc_pat", 32'(pat_count), 0);
    check("s6_coinc_sig", 32'(signature), 0);
    for (int v = 0; v < NPAT; v++) issue(0, 1, v, (v != 0));
    idle(2);
    check_good_sweep("s6");

    // Scenario 7: random vectors and outputs with gaps, model-checked sample by sample
    issue(1, 0, 0, 0);
    for (int v = 0; v < NPAT; v++) begin
      while ($urandom_range(99) < 20) idle(1);
      issue(0, 1, ($urandom_range(3) == 0) ? v : $urandom_range(255), 1'($urandom_range(1)));
    end
    idle(2);
    wait_done("s7");
    check("s7_pat", 32'(pat_count), 256);
    check("s7_pass", 32'(pass), 32'(m_err == 0 && !m_seq));

    idle(2);
    check("final_queue_drained", 32'(q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
